// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and sizing helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Number of divider cycles needed to produce a full quotient.
  function automatic int div_iters(input int width, input int k);
    return width / k;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Unsigned restoring divider producing DIV_K quotient bits per cycle.
// done is high in the cycle whose closing edge performs the last step; quot/rem are final after it.
module iter_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV_K = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int ITERS = div_iters(WIDTH, DIV_K);
  localparam int CW    = $clog2(ITERS + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH:0]   r_t;
  logic [WIDTH-1:0] q_t;

  // The partial remainder needs one extra bit while the next dividend bit is shifted in.
  always_comb begin
    r_t = {1'b0, r_reg};
    q_t = q_reg;
    for (int k = 0; k < DIV_K; k++) begin
      r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
      q_t = {q_t[WIDTH-2:0], 1'b0};
      if (r_t >= {1'b0, den}) begin
        r_t    = r_t - {1'b0, den};
        q_t[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      cnt <= '0;
    end else if (start) begin
      r_reg <= '0;
      q_reg <= dividend;
      den   <= divisor;
      cnt   <= CW'(ITERS);
    end else if (cnt != '0) begin
      r_reg <= r_t[WIDTH-1:0];
      q_reg <= q_t;
      cnt   <= cnt - CW'(1);
    end
  end

  assign done = (cnt == CW'(1));
  assign quot = q_reg;
  assign rem  = r_reg;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the execute stage.
// Pipelined MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO, flush cancels the in-flight op.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 1,
  parameter int DIV_K      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             flush,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_signed;
  logic               accept;
  logic               acc_mul;
  logic               acc_div;
  logic               req_signed;
  logic [WIDTH-1:0]   div_dividend;
  logic [WIDTH-1:0]   div_divisor;
  logic               div_done;
  logic [WIDTH-1:0]   div_quot;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;
  logic [MUL_STAGES-1:0] mul_vld;

  assign req_ready  = (state == ST_IDLE) && !flush;
  assign busy       = (state != ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign acc_mul    = accept && ((req_op == OP_MULT) || (req_op == OP_MULTU));
  assign acc_div    = accept && ((req_op == OP_DIV) || (req_op == OP_DIVU));
  assign req_signed = (req_op == OP_MULT) || (req_op == OP_DIV);

  assign div_dividend = (req_signed && req_src1[WIDTH-1]) ? -req_src1 : req_src1;
  assign div_divisor  = (req_signed && req_src2[WIDTH-1]) ? -req_src2 : req_src2;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a      <= req_src1;
      op_b      <= req_src2;
      op_signed <= req_signed;
    end
  end

  // Sign-extending both operands makes the low 2*WIDTH bits correct for signed and unsigned alike.
  assign product = {{WIDTH{op_signed && op_a[WIDTH-1]}}, op_a} *
                   {{WIDTH{op_signed && op_b[WIDTH-1]}}, op_b};

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_result = product;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        pipe[0] <= product;
        for (int k = 1; k < MUL_STAGES - 1; k++) begin
          pipe[k] <= pipe[k-1];
        end
      end
      assign mul_result = pipe[MUL_STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mul_vld <= '0;
    end else begin
      mul_vld[0] <= acc_mul;
      for (int k = 1; k < MUL_STAGES; k++) begin
        mul_vld[k] <= mul_vld[k-1];
      end
    end
  end

  iter_divider #(
    .WIDTH (WIDTH),
    .DIV_K (DIV_K)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (acc_div),
    .abort    (flush),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Divide by zero bypasses the sign fixup so the dividend comes back exactly as given.
  always_comb begin
    fix_lo = (op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) ? -div_quot : div_quot;
    fix_hi = (op_signed && op_a[WIDTH-1]) ? -div_rem : div_rem;
    if (op_b == '0) begin
      fix_lo = '1;
      fix_hi = op_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hi         <= '0;
      lo         <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MULT, OP_MULTU: state <= ST_MUL;
              OP_DIV, OP_DIVU:   state <= ST_DIV;
              OP_MTHI: begin
                hi         <= req_src1;
                resp_valid <= 1'b1;
              end
              OP_MTLO: begin
                lo         <= req_src1;
                resp_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (mul_vld[MUL_STAGES-1]) begin
            hi         <= mul_result[2*WIDTH-1:WIDTH];
            lo         <= mul_result[WIDTH-1:0];
            resp_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush) begin
            hi         <= fix_hi;
            lo         <= fix_lo;
            resp_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
